// File: rtl/decode_queue_if.sv
// Fetch-side and decode-side handshake bundle for the decode queue.
// Both handshakes use the same rule: a transfer happens on a rising clk edge where valid && ready.
interface decode_queue_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 32
);
  logic                   fetch_valid;
  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [INSTR_WIDTH-1:0] fetch_instr;
  logic                   fetch_ready;

  logic                   dec_valid;
  logic                   dec_ready;
  logic [ADDR_WIDTH-1:0]  dec_pc;
  logic [6:0]             dec_opcode;
  logic [4:0]             dec_rd;
  logic [4:0]             dec_rs1;
  logic [4:0]             dec_rs2;
  logic [2:0]             dec_funct3;
  logic [6:0]             dec_funct7;
  logic [31:0]            dec_imm;
  logic                   dec_illegal;

  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr, dec_ready,
    output fetch_ready, dec_valid, dec_pc, dec_opcode, dec_rd, dec_rs1,
           dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_illegal
  );

  modport master (
    output fetch_valid, fetch_pc, fetch_instr, dec_ready,
    input  fetch_ready, dec_valid, dec_pc, dec_opcode, dec_rd, dec_rs1,
           dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_illegal
  );
endinterface

// File: rtl/decode_queue.sv
// Circular FIFO of (pc, instr) pairs between fetch and rename, with RV32I field
// decode of the head entry and a flush point for branch redirects.
module decode_queue #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  decode_queue_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic                   push;
  logic                   pop;
  logic                   not_empty;

  // Ready depends only on registered occupancy; a full queue never takes a pop-bypass.
  assign bus.fetch_ready = (count != CNT_FULL);
  assign not_empty       = (count != '0);
  assign bus.dec_valid   = not_empty;
  assign push            = bus.fetch_valid & bus.fetch_ready;
  assign pop             = not_empty & bus.dec_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= bus.fetch_pc;
      instr_mem[wr_ptr] <= bus.fetch_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  logic [31:0] head;
  logic [31:0] imm;
  logic        illegal;
  logic        no_rd;

  assign head = instr_mem[rd_ptr];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    no_rd   = 1'b0;
    case (head[6:0])
      7'b0110111, 7'b0010111: imm = {head[31:12], 12'b0};
      7'b1101111: imm = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      7'b1100111, 7'b0000011, 7'b0010011: imm = {{20{head[31]}}, head[31:20]};
      7'b0100011: begin
        imm   = {{20{head[31]}}, head[31:25], head[11:7]};
        no_rd = 1'b1;
      end
      7'b1100011: begin
        imm   = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
        no_rd = 1'b1;
      end
      7'b0110011: imm = '0;
      default: begin
        illegal = 1'b1;
        no_rd   = 1'b1;
      end
    endcase
  end

  assign bus.dec_pc      = pc_mem[rd_ptr];
  assign bus.dec_opcode  = head[6:0];
  assign bus.dec_rd      = no_rd ? 5'd0 : head[11:7];
  assign bus.dec_rs1     = head[19:15];
  assign bus.dec_rs2     = head[24:20];
  assign bus.dec_funct3  = head[14:12];
  assign bus.dec_funct7  = head[31:25];
  assign bus.dec_imm     = imm;
  // Stale storage behind an empty queue must never look like an illegal instruction.
  assign bus.dec_illegal = illegal & not_empty;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: scoreboard of accepted (pc, instr) pairs checked at
// every pop against an independent RV32I decode model, plus directed field checks.
module tb_decode_queue;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] count;
  logic       mon_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [43:0] exp_q[$];

  decode_queue_if #(.ADDR_WIDTH(12), .INSTR_WIDTH(32)) bus ();

  decode_queue #(.ADDR_WIDTH(12), .INSTR_WIDTH(32), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void decode_ref(input logic [31:0] i, output logic [31:0] imm,
                                     output logic [4:0] rd, output logic ill);
    ill = 1'b0;
    imm = 32'd0;
    case (i[6:0])
      7'h37, 7'h17: imm = {i[31:12], 12'h000};
      7'h6F: imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      7'h67, 7'h03, 7'h13: imm = 32'($signed(i[31:20]));
      7'h23: imm = 32'($signed({i[31:25], i[11:7]}));
      7'h63: imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      7'h33: imm = 32'd0;
      default: ill = 1'b1;
    endcase
    rd = (i[6:0] == 7'h23 || i[6:0] == 7'h63 || ill) ? 5'd0 : i[11:7];
  endfunction

  // Scoreboard: occupancy and head contents are compared before the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [43:0] e;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        ill;
      check("occupancy", 32'(count), 32'(exp_q.size()));
      if (!bus.dec_valid) check("illegal_idle", 32'(bus.dec_illegal), 32'd0);
      if (reset || flush) begin
        exp_q.delete();
      end else begin
        if (bus.dec_valid && bus.dec_ready) begin
          check("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            decode_ref(e[31:0], imm, rd, ill);
            check("sb_pc", 32'(bus.dec_pc), 32'(e[43:32]));
            check("sb_opcode", 32'(bus.dec_opcode), 32'(e[6:0]));
            check("sb_rs1", 32'(bus.dec_rs1), 32'(e[19:15]));
            check("sb_imm", bus.dec_imm, imm);
            check("sb_rd", 32'(bus.dec_rd), 32'(rd));
            check("sb_illegal", 32'(bus.dec_illegal), 32'(ill));
          end
        end
        if (bus.fetch_valid && bus.fetch_ready) exp_q.push_back({bus.fetch_pc, bus.fetch_instr});
      end
    end
  end

  initial begin
    logic [6:0]  ops [9];
    logic [31:0] dir_instr [4];
    logic [31:0] dir_imm [4];
    logic [4:0]  dir_rd [4];
    logic [31:0] r;
    logic [11:0] last_pc;

    ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    dir_instr = '{32'hFE20AE23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
    dir_imm   = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
    dir_rd    = '{5'd0, 5'd0, 5'd5, 5'd1};

    bus.fetch_valid = 1'b0;
    bus.fetch_pc    = '0;
    bus.fetch_instr = '0;
    bus.dec_ready   = 1'b0;
    step();
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    check("rst_illegal", 32'(bus.dec_illegal), 32'd0);

    // Single push, head visible after the edge.
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 12'h000;
    bus.fetch_instr = 32'h00500093;
    step();
    bus.fetch_valid = 1'b0;
    check("t1_dec_valid", 32'(bus.dec_valid), 32'd1);
    check("t1_opcode", 32'(bus.dec_opcode), 32'h13);
    check("t1_rd", 32'(bus.dec_rd), 32'd1);
    check("t1_rs1", 32'(bus.dec_rs1), 32'd0);
    check("t1_imm", bus.dec_imm, 32'd5);
    check("t1_count", 32'(count), 32'd1);

    // Fill to full, refused fifth offer, then one pop.
    for (int i = 1; i < 4; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 12'(4 * i);
      bus.fetch_instr = 32'h00100093 + 32'(i << 20);
      step();
    end
    check("t2_count_full", 32'(count), 32'd4);
    check("t2_ready_full", 32'(bus.fetch_ready), 32'd0);
    bus.fetch_pc    = 12'h010;
    bus.fetch_instr = 32'h00000033;
    step();
    check("t2_refused", 32'(count), 32'd4);
    bus.dec_ready = 1'b1;
    step();
    bus.dec_ready   = 1'b0;
    bus.fetch_valid = 1'b0;
    check("t2_count_after_pop", 32'(count), 32'd3);
    check("t2_ready_after_pop", 32'(bus.fetch_ready), 32'd1);
    check("t2_head_pc", 32'(bus.dec_pc), 32'h004);

    // Drain, then streaming push+pop through pointer wrap.
    bus.dec_ready = 1'b1;
    for (int k = 0; k < 20 && count != 0; k++) step();
    check("t3_drained", 32'(count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      r = $urandom();
      last_pc = 12'h100 + 12'(4 * i);
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = last_pc;
      bus.fetch_instr = {r[31:7], ops[$urandom_range(0, 8)]};
      step();
      check("t3_count", 32'(count), 32'd1);
      check("t3_dec_pc", 32'(bus.dec_pc), 32'(last_pc));
    end
    bus.fetch_valid = 1'b0;
    step();
    check("t3_empty", 32'(count), 32'd0);
    bus.dec_ready = 1'b0;

    // Immediate formats, checked at the head one by one.
    for (int i = 0; i < 4; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 12'h200 + 12'(4 * i);
      bus.fetch_instr = dir_instr[i];
      step();
    end
    bus.fetch_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_imm", bus.dec_imm, dir_imm[i]);
      check("t4_rd", 32'(bus.dec_rd), 32'(dir_rd[i]));
      check("t4_illegal", 32'(bus.dec_illegal), 32'd0);
      bus.dec_ready = 1'b1;
      step();
      bus.dec_ready = 1'b0;
    end
    check("t4_empty", 32'(count), 32'd0);

    // Flush with a simultaneous offer.
    for (int i = 0; i < 3; i++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 12'h300 + 12'(4 * i);
      bus.fetch_instr = 32'h00000013;
      step();
    end
    check("t5_count3", 32'(count), 32'd3);
    bus.fetch_pc    = 12'h3F0;
    bus.fetch_instr = 32'h00700093;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.fetch_valid = 1'b0;
    check("t5_count", 32'(count), 32'd0);
    check("t5_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("t5_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    step();
    check("t5_offer_dropped", 32'(count), 32'd0);

    // Illegal opcode, then reset with two entries queued.
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 12'h400;
    bus.fetch_instr = 32'hFFFFFFFF;
    step();
    check("t6_illegal", 32'(bus.dec_illegal), 32'd1);
    check("t6_imm", bus.dec_imm, 32'd0);
    check("t6_rd", 32'(bus.dec_rd), 32'd0);
    bus.fetch_pc    = 12'h404;
    bus.fetch_instr = 32'h00000033;
    step();
    bus.fetch_valid = 1'b0;
    check("t6_count2", 32'(count), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("t6_rst_illegal", 32'(bus.dec_illegal), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
